// File: rtl/sync_fifo_param_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_if
// Handshake/data bundle for sync_fifo_param.
//   master : producer/consumer side (drives data_in, wr_en, rd_en)
//   slave  : FIFO side (drives data_out, status flags and count)
// Parameters must match the FIFO instance connected to it.
// -----------------------------------------------------------------------------
interface sync_fifo_param_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CW-1:0]         count;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );
endinterface

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with registered occupancy count, programmable
// almost-full / almost-empty thresholds and registered write/overflow/underflow
// status.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : sync_fifo_param_if.slave
//            data_in/wr_en/rd_en in; data_out, wr_ack, overflow, underflow,
//            full, empty, almostfull, almostempty, count out
//
// Build option
//   FIFO_FWFT_EN : first-word-fall-through read. data_out shows mem[rd_ptr]
//                  combinationally while not empty (0 when empty) and rd_en
//                  pops it. Undefined: data_out registered on read accept.
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    sync_fifo_param_if.slave    bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          wr_ack;
    logic          overflow;
    logic          underflow;
    logic          full;
    logic          empty;
    logic          wr_acc;
    logic          rd_acc;

    // Flags come straight from the registered count.
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // When full, a simultaneous read still goes through and the write is
    // rejected; when empty, the write goes through and the read is rejected.
    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;

    // Pointers are exactly AW bits so they wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            wr_ack    <= wr_acc;
            overflow  <= bus.wr_en && full;
            underflow <= bus.rd_en && empty;
        end
    end

    // Storage is not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.data_in;
    end

`ifdef FIFO_FWFT_EN
    assign bus.data_out = empty ? '0 : mem[rd_ptr];
`else
    logic [FIFO_WIDTH-1:0] data_q;

    // Holds across idle and underflow cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      data_q <= '0;
        else if (rd_acc) data_q <= mem[rd_ptr];
    end

    assign bus.data_out = data_q;
`endif

    assign bus.count       = count;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almostfull  = (count >= AF_C) && !full;
    assign bus.almostempty = !empty && (count <= AE_C);
    assign bus.wr_ack      = wr_ack;
    assign bus.overflow    = overflow;
    assign bus.underflow   = underflow;
endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Directed stimulus on a DEPTH=8, WIDTH=16, AF=6, AE=2 FIFO. Every accepted
// write pushes its word into a scoreboard queue; a monitor pops and compares
// whenever the FIFO presents read data. Status/count are checked against
// hand-computed constants after each step.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;
    localparam int W = 16;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q [$];

    sync_fifo_param_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) bus ();

    sync_fifo_param #(
        .FIFO_WIDTH(W), .FIFO_DEPTH(D), .AF_THRESH(6), .AE_THRESH(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge and stay for one cycle.
    task automatic step(input logic w, input logic r, input logic [W-1:0] d);
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.data_in = d;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic wr(input logic [W-1:0] d);
        exp_q.push_back(d);
        step(1'b1, 1'b0, d);
    endtask

    // ---------------------------------------------------------------- monitor
`ifdef FIFO_FWFT_EN
    // Displayed word is consumed while rd_en is high and the FIFO is not empty.
    always @(negedge clk) begin
        if (rst_n && bus.rd_en && !bus.empty) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_underrun: read data 0x%0h with empty scoreboard", bus.data_out);
            end else begin
                check("sb_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
            end
        end
    end
`else
    logic rd_fire;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_fire <= 1'b0;
        else        rd_fire <= bus.rd_en && !bus.empty;
    end

    always @(negedge clk) begin
        if (rd_fire) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_underrun: read data 0x%0h with empty scoreboard", bus.data_out);
            end else begin
                check("sb_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
            end
        end
    end
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(bus.count), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full",  32'(bus.full), 0);
        check("rst_af",    32'(bus.almostfull), 0);
        check("rst_ae",    32'(bus.almostempty), 0);
        check("rst_dout",  32'(bus.data_out), 0);
        check("rst_status", {29'd0, bus.wr_ack, bus.overflow, bus.underflow}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill 1..8 and walk the thresholds.
        for (int i = 1; i <= 8; i++) begin
            wr(W'(i));
            check("fill_count", 32'(bus.count), i);
            check("fill_ack",   32'(bus.wr_ack), 1);
            check("fill_ae",    32'(bus.almostempty), (i <= 2) ? 1 : 0);
            check("fill_af",    32'(bus.almostfull), (i == 6 || i == 7) ? 1 : 0);
            check("fill_full",  32'(bus.full), (i == 8) ? 1 : 0);
        end
        step(1'b1, 1'b0, 16'h0009);
        check("ovf_flag",  32'(bus.overflow), 1);
        check("ovf_ack",   32'(bus.wr_ack), 0);
        check("ovf_count", 32'(bus.count), 8);

        // Drain 8; monitor checks 1..8 in order.
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 1'b1, '0);
            check("drain_count", 32'(bus.count), i);
        end
        check("drain_empty", 32'(bus.empty), 1);
        step(1'b0, 1'b1, '0);
        check("udf_flag", 32'(bus.underflow), 1);
`ifdef FIFO_FWFT_EN
        check("udf_dout", 32'(bus.data_out), 0);
`else
        check("udf_dout", 32'(bus.data_out), 32'h0008);
`endif

        // Simultaneous access at count 4.
        for (int i = 0; i < 4; i++) wr(W'(16'h0010 + i));
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(W'(16'h0020 + i));
            step(1'b1, 1'b1, W'(16'h0020 + i));
            check("rw_count", 32'(bus.count), 4);
        end
        for (int i = 0; i < 4; i++) wr(W'(16'h0040 + i));
        check("rw_full", 32'(bus.full), 1);
        step(1'b1, 1'b1, 16'h0050);   // write rejected, read accepted
        check("rw_full_ovf",   32'(bus.overflow), 1);
        check("rw_full_count", 32'(bus.count), 7);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, '0);
        check("rw_empty", 32'(bus.empty), 1);
        exp_q.push_back(16'h0060);
        step(1'b1, 1'b1, 16'h0060);   // write accepted, read rejected
        check("rw_empty_udf",   32'(bus.underflow), 1);
        check("rw_empty_ack",   32'(bus.wr_ack), 1);
        check("rw_empty_count", 32'(bus.count), 1);
        step(1'b0, 1'b1, '0);
        check("rw_drained", 32'(bus.empty), 1);

        // Reset mid-burst with 5 words stored.
        for (int i = 0; i < 5; i++) wr(W'(16'h0070 + i));
        check("mid_count", 32'(bus.count), 5);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_count", 32'(bus.count), 0);
        check("mid_rst_empty", 32'(bus.empty), 1);
        check("mid_rst_dout",  32'(bus.data_out), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, 1'b1, '0);
        check("mid_rst_udf", 32'(bus.underflow), 1);

        // Three fill/drain rounds of 5 words cross the pointer wrap.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) begin
                wr(W'(16'h0100 * (r + 1) + i));
`ifdef FIFO_FWFT_EN
                if (i == 0) check("fwft_first", 32'(bus.data_out), 32'(16'h0100 * (r + 1)));
`endif
            end
            check("wrap_count", 32'(bus.count), 5);
            for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);
            check("wrap_empty", 32'(bus.empty), 1);
        end

        @(posedge clk); #1;
        check("sb_left", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
